// File: rtl/clock_ctrl_pkg.sv
// Shared state encodings, BCD limits and alarm defaults for the clock setting controller.
package clock_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN   = 3'd0,
    ST_SET_H = 3'd1,
    ST_SET_M = 3'd2,
    ST_ALM_H = 3'd3,
    ST_ALM_M = 3'd4
  } state_t;

  localparam logic [7:0] BCD_HOUR_MAX   = 8'h23;
  localparam logic [7:0] BCD_MIN_MAX    = 8'h59;
  localparam logic [7:0] ALARM_HOUR_RST = 8'h07;
  localparam logic [7:0] ALARM_MIN_RST  = 8'h00;

  // Two-digit BCD increment that wraps to 00 after limit; result is always valid BCD.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] limit);
    logic [7:0] r;
    if (v == limit)
      r = 8'h00;
    else if (v[3:0] >= 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic state_t mode_step(input state_t s);
    state_t n;
    case (s)
      ST_RUN:   n = ST_SET_H;
      ST_SET_H: n = ST_SET_M;
      ST_SET_M: n = ST_ALM_H;
      ST_ALM_H: n = ST_ALM_M;
      default:  n = ST_RUN;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Raw key synchronizer plus debouncer; emits one registered pulse per accepted press.
module key_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          stable_reg;
  logic          stable_d_reg;
  logic          pulse_reg;

  // cnt_reg counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg     <= 2'b00;
      cnt_reg      <= '0;
      stable_reg   <= 1'b0;
      stable_d_reg <= 1'b0;
      pulse_reg    <= 1'b0;
    end else begin
      sync_reg     <= {sync_reg[0], key};
      stable_d_reg <= stable_reg;
      pulse_reg    <= stable_reg & ~stable_d_reg;
      if (sync_reg[1] == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE - 1)) begin
        cnt_reg    <= '0;
        stable_reg <= sync_reg[1];
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign pulse = pulse_reg;

endmodule

// File: rtl/clock_set_ctrl.sv
// Two-key clock/alarm setting controller: mode stepping, time adjust pulses, alarm set and ring.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode,
  input  logic       key_inc,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  output logic       en,
  output logic       adjust_hour,
  output logic       adjust_minute,
  output logic [2:0] mode,
  output logic [7:0] alarm_hour,
  output logic [7:0] alarm_min,
  output logic       alarm_on,
  output logic       ring
);

  logic mode_pulse;
  logic inc_pulse;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_mode_db (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_mode),
    .pulse (mode_pulse)
  );

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_inc_db (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key_inc),
    .pulse (inc_pulse)
  );

  state_t     state_reg, state_next;
  logic       en_reg, en_next;
  logic       adj_h_reg, adj_h_next;
  logic       adj_m_reg, adj_m_next;
  logic [7:0] alarm_hour_reg, alarm_hour_next;
  logic [7:0] alarm_min_reg, alarm_min_next;
  logic       alarm_on_reg, alarm_on_next;
  logic       ring_reg, ring_next;
  logic       silence_reg, silence_next;
  logic       alarm_match;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_RUN;
      en_reg         <= 1'b0;
      adj_h_reg      <= 1'b0;
      adj_m_reg      <= 1'b0;
      alarm_hour_reg <= ALARM_HOUR_RST;
      alarm_min_reg  <= ALARM_MIN_RST;
      alarm_on_reg   <= 1'b0;
      ring_reg       <= 1'b0;
      silence_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      en_reg         <= en_next;
      adj_h_reg      <= adj_h_next;
      adj_m_reg      <= adj_m_next;
      alarm_hour_reg <= alarm_hour_next;
      alarm_min_reg  <= alarm_min_next;
      alarm_on_reg   <= alarm_on_next;
      ring_reg       <= ring_next;
      silence_reg    <= silence_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    adj_h_next      = 1'b0;
    adj_m_next      = 1'b0;
    alarm_hour_next = alarm_hour_reg;
    alarm_min_next  = alarm_min_reg;
    alarm_on_next   = alarm_on_reg;
    ring_next       = ring_reg;
    silence_next    = silence_reg;
    alarm_match     = alarm_on_reg && (hour == alarm_hour_reg) &&
                      (min == alarm_min_reg) && (sec == 8'h00);

    // Leaving the alarm minute (or disarming) ends both the ring and the silence window.
    if (!alarm_on_reg || (min != alarm_min_reg)) begin
      ring_next    = 1'b0;
      silence_next = 1'b0;
    end

    if (ring_reg) begin
      // While ringing, any key only silences the alarm.
      if (mode_pulse || inc_pulse) begin
        ring_next    = 1'b0;
        silence_next = 1'b1;
      end
    end else begin
      if (alarm_match && !silence_reg)
        ring_next = 1'b1;
      if (mode_pulse) begin
        state_next = mode_step(state_reg);
      end else if (inc_pulse) begin
        case (state_reg)
          ST_SET_H: adj_h_next      = 1'b1;
          ST_SET_M: adj_m_next      = 1'b1;
          ST_ALM_H: alarm_hour_next = bcd_inc(alarm_hour_reg, BCD_HOUR_MAX);
          ST_ALM_M: alarm_min_next  = bcd_inc(alarm_min_reg, BCD_MIN_MAX);
          default:  alarm_on_next   = ~alarm_on_reg;
        endcase
      end
    end

    en_next = (state_next != ST_SET_H) && (state_next != ST_SET_M);
  end

  assign en            = en_reg;
  assign adjust_hour   = adj_h_reg;
  assign adjust_minute = adj_m_reg;
  assign mode          = state_reg;
  assign alarm_hour    = alarm_hour_reg;
  assign alarm_min     = alarm_min_reg;
  assign alarm_on      = alarm_on_reg;
  assign ring          = ring_reg;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with DEBOUNCE=4: key latency, mode stepping, set, alarm and reset.
module tb_clock_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_mode;
  logic       key_inc;
  logic [7:0] hour;
  logic [7:0] min;
  logic [7:0] sec;
  logic       en;
  logic       adjust_hour;
  logic       adjust_minute;
  logic [2:0] mode;
  logic [7:0] alarm_hour;
  logic [7:0] alarm_min;
  logic       alarm_on;
  logic       ring;

  int pass_cnt  = 0;
  int total_cnt = 0;

  int   adj_h_cycles = 0, adj_h_rises = 0;
  int   adj_m_cycles = 0, adj_m_rises = 0;
  int   illegal_cnt  = 0;
  logic adj_h_prev   = 1'b0;
  logic adj_m_prev   = 1'b0;

  clock_set_ctrl #(.DEBOUNCE(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_mode      (key_mode),
    .key_inc       (key_inc),
    .hour          (hour),
    .min           (min),
    .sec           (sec),
    .en            (en),
    .adjust_hour   (adjust_hour),
    .adjust_minute (adjust_minute),
    .mode          (mode),
    .alarm_hour    (alarm_hour),
    .alarm_min     (alarm_min),
    .alarm_on      (alarm_on),
    .ring          (ring)
  );

  always #5 clk = ~clk;

  // Pulse counters and adjust-legality observer, sampled away from the active edge.
  always @(negedge clk) begin
    if (adjust_hour) adj_h_cycles++;
    if (adjust_hour && !adj_h_prev) adj_h_rises++;
    if (adjust_minute) adj_m_cycles++;
    if (adjust_minute && !adj_m_prev) adj_m_rises++;
    adj_h_prev = adjust_hour;
    adj_m_prev = adjust_minute;
    if (adjust_hour && adjust_minute) illegal_cnt++;
    if (adjust_hour && mode !== 3'd1) illegal_cnt++;
    if (adjust_minute && mode !== 3'd2) illegal_cnt++;
  end

  task automatic clear_counters();
    adj_h_cycles = 0; adj_h_rises = 0;
    adj_m_cycles = 0; adj_m_rises = 0;
  endtask

  task automatic press(input logic m, input logic i);
    key_mode = m;
    key_inc  = i;
    repeat (10) @(negedge clk);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    repeat (10) @(negedge clk);
    $display("press mode_key=%0b inc_key=%0b -> mode=%0d alarm=%h:%h on=%0b ring=%0b",
             m, i, mode, alarm_hour, alarm_min, alarm_on, ring);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key_mode = 1'b0; key_inc = 1'b0;
    hour = 8'h12; min = 8'h34; sec = 8'h00;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({mode, en, adjust_hour, adjust_minute, alarm_hour, alarm_min, alarm_on, ring} !==
        {3'd0, 1'b0, 1'b0, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_values: mode=%0d en=%0b adj=%0b%0b alarm=%h:%h on=%0b ring=%0b required mode=0 en=0 adj=00 alarm=07:00 on=0 ring=0",
               mode, en, adjust_hour, adjust_minute, alarm_hour, alarm_min, alarm_on, ring);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (en !== 1'b1 || mode !== 3'd0)
      $display("FAIL reset_release: en=%0b mode=%0d required en=1 mode=0", en, mode);
    else pass_cnt++;
    $display("reset done");
  endtask

  task automatic test_mode_stepping();
    int   exp_mode;
    logic exp_en;
    for (int i = 0; i < 5; i++) begin
      exp_mode = (i + 1) % 5;
      exp_en   = (exp_mode == 1 || exp_mode == 2) ? 1'b0 : 1'b1;
      key_mode = 1'b1;
      repeat (7) @(negedge clk);
      total_cnt++;
      if (mode !== 3'(i))
        $display("FAIL mode_early%0d: mode=%0d required %0d", i, mode, i);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (mode !== 3'(exp_mode))
        $display("FAIL mode_step%0d: mode=%0d required %0d", i, mode, exp_mode);
      else pass_cnt++;
      total_cnt++;
      if (en !== exp_en)
        $display("FAIL en_step%0d: en=%0b required %0b", i, en, exp_en);
      else pass_cnt++;
      repeat (2) @(negedge clk);
      key_mode = 1'b0;
      repeat (10) @(negedge clk);
      $display("mode press %0d -> mode=%0d en=%0b", i, mode, en);
    end
  endtask

  task automatic test_clock_set();
    press(1'b1, 1'b0);
    clear_counters();
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
    total_cnt++;
    if (adj_h_rises != 3 || adj_h_cycles != 3 || adj_m_cycles != 0)
      $display("FAIL set_hour: hour pulses=%0d cycles=%0d minute cycles=%0d required 3/3/0",
               adj_h_rises, adj_h_cycles, adj_m_cycles);
    else pass_cnt++;
    press(1'b1, 1'b0);
    clear_counters();
    for (int i = 0; i < 3; i++) press(1'b0, 1'b1);
    total_cnt++;
    if (adj_m_rises != 3 || adj_m_cycles != 3 || adj_h_cycles != 0)
      $display("FAIL set_minute: minute pulses=%0d cycles=%0d hour cycles=%0d required 3/3/0",
               adj_m_rises, adj_m_cycles, adj_h_cycles);
    else pass_cnt++;
  endtask

  task automatic test_alarm_wrap();
    press(1'b1, 1'b0);
    for (int i = 1; i <= 24; i++) begin
      press(1'b0, 1'b1);
      if (i == 3) begin
        total_cnt++;
        if (alarm_hour !== 8'h10) $display("FAIL alarm_hour_carry: got %h required 10", alarm_hour);
        else pass_cnt++;
      end
      if (i == 16) begin
        total_cnt++;
        if (alarm_hour !== 8'h23) $display("FAIL alarm_hour_max: got %h required 23", alarm_hour);
        else pass_cnt++;
      end
      if (i == 17) begin
        total_cnt++;
        if (alarm_hour !== 8'h00) $display("FAIL alarm_hour_wrap: got %h required 00", alarm_hour);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (alarm_hour !== 8'h07) $display("FAIL alarm_hour_end: got %h required 07", alarm_hour);
    else pass_cnt++;

    press(1'b1, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      press(1'b0, 1'b1);
      if (i == 10) begin
        total_cnt++;
        if (alarm_min !== 8'h10) $display("FAIL alarm_min_carry: got %h required 10", alarm_min);
        else pass_cnt++;
      end
      if (i == 59) begin
        total_cnt++;
        if (alarm_min !== 8'h59) $display("FAIL alarm_min_max: got %h required 59", alarm_min);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (alarm_min !== 8'h00) $display("FAIL alarm_min_wrap: got %h required 00", alarm_min);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    key_inc = 1'b1;
    repeat (3) @(negedge clk);
    key_inc = 1'b0;
    repeat (20) @(negedge clk);
    total_cnt++;
    if (alarm_min !== 8'h00) $display("FAIL glitch_reject: alarm_min=%h required 00", alarm_min);
    else pass_cnt++;
    $display("glitch applied -> alarm_min=%h", alarm_min);
    press(1'b1, 1'b0);
    total_cnt++;
    if (mode !== 3'd0) $display("FAIL back_to_run: mode=%0d required 0", mode);
    else pass_cnt++;
  endtask

  task automatic test_alarm_ring();
    press(1'b0, 1'b1);
    total_cnt++;
    if (alarm_on !== 1'b1) $display("FAIL alarm_arm: alarm_on=%0b required 1", alarm_on);
    else pass_cnt++;
    hour = 8'h07; min = 8'h00; sec = 8'h00;
    @(negedge clk);
    total_cnt++;
    if (ring !== 1'b1) $display("FAIL ring_set: ring=%0b required 1", ring);
    else pass_cnt++;
    key_inc = 1'b1;
    repeat (7) @(negedge clk);
    total_cnt++;
    if (ring !== 1'b1) $display("FAIL ring_hold: ring=%0b required 1", ring);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (ring !== 1'b0) $display("FAIL ring_silence: ring=%0b required 0", ring);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    key_inc = 1'b0;
    repeat (10) @(negedge clk);
    total_cnt++;
    if (ring !== 1'b0 || alarm_on !== 1'b1 || mode !== 3'd0)
      $display("FAIL silence_consumed: ring=%0b alarm_on=%0b mode=%0d required 0/1/0", ring, alarm_on, mode);
    else pass_cnt++;
    sec = 8'h30;
    repeat (5) @(negedge clk);
    total_cnt++;
    if (ring !== 1'b0) $display("FAIL no_rering: ring=%0b required 0", ring);
    else pass_cnt++;
    min = 8'h01;
    repeat (2) @(negedge clk);
    min = 8'h00; sec = 8'h00;
    @(negedge clk);
    total_cnt++;
    if (ring !== 1'b1) $display("FAIL ring_rearm: ring=%0b required 1", ring);
    else pass_cnt++;
    min = 8'h01;
    @(negedge clk);
    total_cnt++;
    if (ring !== 1'b0) $display("FAIL ring_min_clear: ring=%0b required 0", ring);
    else pass_cnt++;
    $display("alarm ring sequence done ring=%0b", ring);
    hour = 8'h12; min = 8'h34;
    repeat (2) @(negedge clk);
    press(1'b0, 1'b1);
    total_cnt++;
    if (alarm_on !== 1'b0) $display("FAIL alarm_disarm: alarm_on=%0b required 0", alarm_on);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    press(1'b1, 1'b0);
    clear_counters();
    press(1'b1, 1'b1);
    total_cnt++;
    if (mode !== 3'd2 || adj_h_cycles != 0 || adj_m_cycles != 0)
      $display("FAIL simultaneous: mode=%0d hour cycles=%0d minute cycles=%0d required 2/0/0",
               mode, adj_h_cycles, adj_m_cycles);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) press(1'b1, 1'b0);
    total_cnt++;
    if (mode !== 3'd0) $display("FAIL sim_return: mode=%0d required 0", mode);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_press();
    key_mode = 1'b1;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({mode, en, adjust_hour, adjust_minute, alarm_hour, alarm_min, alarm_on, ring} !==
        {3'd0, 1'b0, 1'b0, 1'b0, 8'h07, 8'h00, 1'b0, 1'b0})
      $display("FAIL reset_mid_press: mode=%0d en=%0b adj=%0b%0b alarm=%h:%h on=%0b ring=%0b required mode=0 en=0 adj=00 alarm=07:00 on=0 ring=0",
               mode, en, adjust_hour, adjust_minute, alarm_hour, alarm_min, alarm_on, ring);
    else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (en !== 1'b1 || mode !== 3'd0)
      $display("FAIL reset_abort: en=%0b mode=%0d required en=1 mode=0", en, mode);
    else pass_cnt++;
    repeat (6) @(negedge clk);
    total_cnt++;
    if (mode !== 3'd0) $display("FAIL requalify_early: mode=%0d required 0", mode);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (mode !== 3'd1) $display("FAIL requalify: mode=%0d required 1", mode);
    else pass_cnt++;
    key_mode = 1'b0;
    repeat (10) @(negedge clk);
    $display("reset mid-press done mode=%0d", mode);
  endtask

  task automatic test_adjust_legality();
    total_cnt++;
    if (illegal_cnt != 0)
      $display("FAIL adjust_legality: illegal adjust cycles=%0d required 0", illegal_cnt);
    else pass_cnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mode_stepping();
    test_clock_set();
    test_alarm_wrap();
    test_glitch();
    test_alarm_ring();
    test_simultaneous();
    test_reset_mid_press();
    test_adjust_legality();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
